cardinal_dmem_arbiter: RTL

Parametrised shared data memory with a round-robin arbiter. It lets NUM_CH Cardinal processor nodes share one DEPTH x DATA_W data memory in place of one private 256x64 dmem per node. It grants one access per cycle, supplies a per-channel stall and a registered read-return with a valid pulse, and sits between the processor nodes and the memory array in multi-node builds.

---
 rtl/cardinal_dmem_arbiter_if.sv | 25 ++
 rtl/cardinal_dmem_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/cardinal_dmem_arbiter_if.sv
// Channel-side bus bundle for the shared data memory arbiter.
// Channel k occupies bit k of the vectors and slice k of the packed address/data buses.
interface cardinal_dmem_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
);
  logic [NUM_CH-1:0]        Ch_MemEn;
  logic [NUM_CH-1:0]        Ch_WrEn;
  logic [NUM_CH*ADDR_W-1:0] Ch_Addr;
  logic [NUM_CH*DATA_W-1:0] Ch_DataIn;
  logic [NUM_CH*DATA_W-1:0] Ch_DataOut;
  logic [NUM_CH-1:0]        Ch_RdValid;
  logic [NUM_CH-1:0]        Ch_Stall;

  modport master (
    output Ch_MemEn, Ch_WrEn, Ch_Addr, Ch_DataIn,
    input  Ch_DataOut, Ch_RdValid, Ch_Stall
  );

  modport slave (
    input  Ch_MemEn, Ch_WrEn, Ch_Addr, Ch_DataIn,
    output Ch_DataOut, Ch_RdValid, Ch_Stall
  );
endinterface

// File: rtl/cardinal_dmem_arbiter.sv
// Shared DEPTH x DATA_W data memory with a one-grant-per-cycle round-robin arbiter.
// Optional macro DMEM_CONFLICT_CNT_EN adds the saturating Conflict_Count output.
module cardinal_dmem_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic Clock,
  input  logic Reset,
`ifdef DMEM_CONFLICT_CNT_EN
  cardinal_dmem_arbiter_if.slave bus,
  output logic [31:0] Conflict_Count
`else
  cardinal_dmem_arbiter_if.slave bus
`endif
);

  localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] MEM [0:DEPTH-1];

  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         next_ptr;
  logic [PTR_W-1:0]         pos;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_vld;
  logic [NUM_CH-1:0]        grant;
  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_data;
  logic                     in_range;
  logic [MEM_AW-1:0]        mem_idx;
  logic [DATA_W-1:0]        rd_word;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        rd_valid;

  // Round-robin search from rr_ptr upward with wrap; reset suppresses every grant
  always_comb begin : arb
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = PTR_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!Reset && !grant_vld && bus.Ch_MemEn[pos]) begin
        grant_vld = 1'b1;
        grant_idx = pos;
      end
    end
    grant    = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;
    next_ptr = PTR_W'((32'(grant_idx) + 32'd1) % NUM_CH);
  end

  // Route the granted channel's request onto the single memory port
  always_comb begin : sel
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        sel_we   = bus.Ch_WrEn[k];
        sel_addr = bus.Ch_Addr[k*ADDR_W +: ADDR_W];
        sel_data = bus.Ch_DataIn[k*DATA_W +: DATA_W];
      end
    end
    in_range = (32'(sel_addr) < DEPTH);
    mem_idx  = MEM_AW'(sel_addr);
    rd_word  = in_range ? MEM[mem_idx] : '0;
  end

  assign bus.Ch_Stall   = bus.Ch_MemEn & ~grant;
  assign bus.Ch_DataOut = data_out;
  assign bus.Ch_RdValid = rd_valid;

  // Memory contents survive reset; out-of-range writes are dropped
  always_ff @(posedge Clock) begin : mem_wr
    if (grant_vld && sel_we && in_range) begin
      MEM[mem_idx] <= sel_data;
    end
  end

  always_ff @(posedge Clock) begin : state
    if (Reset) begin
      rr_ptr   <= '0;
      rd_valid <= '0;
      data_out <= '0;
    end else begin
      rd_valid <= (grant_vld && !sel_we) ? grant : '0;
      if (grant_vld) begin
        rr_ptr <= next_ptr;
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (grant[k] && !sel_we) begin
          data_out[k*DATA_W +: DATA_W] <= rd_word;
        end
      end
    end
  end

`ifdef DMEM_CONFLICT_CNT_EN
  logic multi_req;

  // Clearing the lowest set bit leaves a nonzero vector only when two or more requests are up
  assign multi_req = |(bus.Ch_MemEn & (bus.Ch_MemEn - NUM_CH'(1)));

  always_ff @(posedge Clock) begin : conflict_cnt
    if (Reset) begin
      Conflict_Count <= '0;
    end else if (multi_req && (Conflict_Count != 32'hFFFF_FFFF)) begin
      Conflict_Count <= Conflict_Count + 32'd1;
    end
  end
`endif

endmodule
